// File: rtl/pusch_cp_inserter.sv
// Cyclic-prefix insertion for the PUSCH transmit chain: ping-pong buffers one IFFT symbol
// and replays its last cp_len samples ahead of the full symbol as one gapless stream.
module pusch_cp_inserter #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_i,
  input  logic [3:0]        nfft_log2,
  input  logic [ADDR_W-1:0] cp_len,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_i,
  output logic              out_valid,
  output logic              out_sym_start,
  output logic              out_cp_flag,
  output logic              sym_done,
  output logic              cfg_err
);

  localparam int              DEPTH    = 2 ** (ADDR_W + 1);
  localparam logic [3:0]      MAX_LOG2 = 4'(ADDR_W);
  localparam logic [ADDR_W:0] ONE_N    = 1;
  localparam logic [ADDR_W-1:0] ONE_A  = 1;

  typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_t;

  function automatic logic [ADDR_W-1:0] last_addr(input logic [3:0] l2);
    logic [ADDR_W:0] n;
    n = ONE_N << l2;
    return ADDR_W'(n - ONE_N);
  endfunction

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] rd_word;
  logic [1:0]          full;
  logic                wr_bank, rd_bank;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [3:0]          cfg_log2 [2];
  logic [ADDR_W-1:0]   cfg_cp   [2];
  rd_state_t           state, state_nxt;

  // Writer: config is sanitised and latched on the first sample of each bank.
  logic              accept, first_wr, log2_bad, cp_bad, set_full;
  logic [3:0]        in_log2_fix, wr_log2;
  logic [ADDR_W:0]   in_n;
  logic [ADDR_W-1:0] in_cp_fix;

  assign in_ready    = !reset && !full[wr_bank];
  assign accept      = in_valid && in_ready;
  assign first_wr    = (wr_addr == '0);
  assign log2_bad    = (nfft_log2 < 4'd6) || (nfft_log2 > MAX_LOG2);
  assign in_log2_fix = log2_bad ? MAX_LOG2 : nfft_log2;
  assign in_n        = ONE_N << in_log2_fix;
  assign cp_bad      = ({1'b0, cp_len} >= in_n);
  assign in_cp_fix   = cp_bad ? ADDR_W'(in_n - ONE_N) : cp_len;
  assign wr_log2     = first_wr ? in_log2_fix : cfg_log2[wr_bank];
  assign set_full    = accept && (wr_addr == last_addr(wr_log2));

  // Reader: start_bank is the bank the next symbol launches from (same bank from IDLE,
  // the other bank when chaining straight out of BODY).
  logic              start_bank, other_full, first_q, first_nxt;
  logic              issue, iss_cp, iss_first, iss_last, clr_full, eff_first;
  logic [ADDR_W-1:0] st_last, st_cp, st_addr, rd_last, eff_addr, rd_addr_nxt;
  rd_state_t         st_state, eff_state;

  assign start_bank = (state == IDLE) ? rd_bank : ~rd_bank;
  assign st_last    = last_addr(cfg_log2[start_bank]);
  assign st_cp      = cfg_cp[start_bank];
  assign st_addr    = (st_cp == '0) ? '0 : st_last - st_cp + ONE_A;
  assign st_state   = (st_cp == '0) ? BODY : CP;
  assign rd_last    = last_addr(cfg_log2[rd_bank]);
  assign other_full = full[~rd_bank] || (set_full && (wr_bank != rd_bank));

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    first_nxt   = 1'b0;
    issue       = (state != IDLE) || full[rd_bank];
    iss_cp      = 1'b0;
    iss_first   = 1'b0;
    iss_last    = 1'b0;
    clr_full    = 1'b0;
    eff_state   = state;
    eff_addr    = rd_addr;
    eff_first   = first_q;
    if (state == IDLE) begin
      eff_state = st_state;
      eff_addr  = st_addr;
      eff_first = 1'b1;
    end
    if (issue) begin
      iss_first = eff_first;
      if (eff_state == CP) begin
        iss_cp = 1'b1;
        if (eff_addr == rd_last) begin
          state_nxt   = BODY;
          rd_addr_nxt = '0;
        end else begin
          state_nxt   = CP;
          rd_addr_nxt = eff_addr + ONE_A;
        end
      end else if (eff_addr == rd_last) begin
        iss_last = 1'b1;
        clr_full = 1'b1;
        if (other_full) begin
          state_nxt   = st_state;
          rd_addr_nxt = st_addr;
          first_nxt   = 1'b1;
        end else begin
          state_nxt   = IDLE;
          rd_addr_nxt = '0;
        end
      end else begin
        state_nxt   = BODY;
        rd_addr_nxt = eff_addr + ONE_A;
      end
    end
  end

  // NOTE: the sample memory carries no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank, wr_addr}] <= {in_r, in_i};
  end

  assign rd_word = mem[{rd_bank, eff_addr}];

  always_ff @(posedge clk) begin
    if (reset) begin
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      state         <= IDLE;
      first_q       <= 1'b0;
      cfg_err       <= 1'b0;
      out_valid     <= 1'b0;
      out_sym_start <= 1'b0;
      out_cp_flag   <= 1'b0;
      sym_done      <= 1'b0;
      out_r         <= '0;
      out_i         <= '0;
      for (int b = 0; b < 2; b++) begin
        cfg_log2[b] <= MAX_LOG2;
        cfg_cp[b]   <= '0;
      end
    end else begin
      cfg_err <= 1'b0;
      if (accept) begin
        if (first_wr) begin
          cfg_log2[wr_bank] <= in_log2_fix;
          cfg_cp[wr_bank]   <= in_cp_fix;
          cfg_err           <= log2_bad || cp_bad;
        end
        wr_addr <= set_full ? '0 : wr_addr + ONE_A;
        if (set_full) wr_bank <= ~wr_bank;
      end
      for (int b = 0; b < 2; b++) begin
        full[b] <= (full[b] | (set_full & (wr_bank == 1'(b)))) &
                   ~(clr_full & (rd_bank == 1'(b)));
      end
      rd_bank       <= rd_bank ^ clr_full;
      state         <= state_nxt;
      rd_addr       <= rd_addr_nxt;
      first_q       <= first_nxt;
      out_valid     <= issue;
      out_sym_start <= iss_first;
      out_cp_flag   <= iss_cp;
      sym_done      <= iss_last;
      out_r         <= issue ? rd_word[2*DATA_W-1:DATA_W] : '0;
      out_i         <= issue ? rd_word[DATA_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_pusch_cp_inserter.sv
// Randomised bench for pusch_cp_inserter: a symbol-level reference model builds the
// expected CP+body stream, plus directed timing and config edge cases.
module tb_pusch_cp_inserter;

  localparam int DATA_W = 15;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready;
  logic [DATA_W-1:0] in_r, in_i, out_r, out_i;
  logic [3:0]        nfft_log2;
  logic [ADDR_W-1:0] cp_len;
  logic              out_valid, out_sym_start, out_cp_flag, sym_done, cfg_err;

  pusch_cp_inserter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .nfft_log2(nfft_log2), .cp_len(cp_len),
    .out_r(out_r), .out_i(out_i), .out_valid(out_valid), .out_sym_start(out_sym_start),
    .out_cp_flag(out_cp_flag), .sym_done(sym_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each expected word is {r, i, cp_flag, sym_start, sym_done}.
  logic [32:0]         exp_q[$];
  logic [2*DATA_W-1:0] sym_buf [2048];
  int sym_cnt = 0, sym_n = 0, sym_cp = 0, exp_err = 0;

  task automatic model_accept(input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] i,
                              input int nlog, input int cp);
    int idx;
    if (sym_cnt == 0) begin
      bit bad = 0;
      int l = nlog;
      if (l < 6 || l > ADDR_W) begin l = ADDR_W; bad = 1; end
      sym_n  = 1 << l;
      sym_cp = cp;
      if (cp >= sym_n) begin sym_cp = sym_n - 1; bad = 1; end
      if (bad) exp_err++;
    end
    sym_buf[sym_cnt] = {r, i};
    sym_cnt++;
    if (sym_cnt == sym_n) begin
      for (int k = 0; k < sym_n + sym_cp; k++) begin
        idx = (k < sym_cp) ? sym_n - sym_cp + k : k - sym_cp;
        exp_q.push_back({sym_buf[idx], 1'(k < sym_cp), 1'(k == 0), 1'(k == sym_n + sym_cp - 1)});
      end
      sym_cnt = 0;
    end
  endtask

  // Per-test statistics gathered by the monitor and driver.
  int valid_cnt, cp_cnt, err_cnt, first_valid, first_done, max_run, cur_run;
  int last_acc, total_acc, stall_acc, ready_back;
  bit stall_seen, mid_sym = 0, mon_en = 0;

  task automatic clear_stats();
    valid_cnt = 0; cp_cnt = 0; err_cnt = 0; first_valid = -1; first_done = -1;
    max_run = 0; cur_run = 0; last_acc = -1; total_acc = 0; stall_acc = -1;
    ready_back = -1; stall_seen = 0; exp_err = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg_err) err_cnt++;
      if (out_valid) begin
        logic [32:0] e;
        valid_cnt++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (out_cp_flag) cp_cnt++;
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          check("extra_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sample", {out_r, out_i, out_cp_flag, out_sym_start, sym_done}, e);
          mid_sym = !e[0];
          if (e[0] && first_done < 0) first_done = cyc;
        end
      end else begin
        cur_run = 0;
        if (mid_sym) begin
          check("gap", out_valid, 1'b1);
          mid_sym = 0;
        end
        check("idle_zero", {out_r, out_i, out_cp_flag, out_sym_start, sym_done}, '0);
      end
    end
  end

  // Streams one symbol; config inputs switch to (chg_nlog, chg_cp) from sample chg_at on.
  task automatic send_sym(input int nlog, input int cp, input bit ramp, input bit gaps,
                          input int chg_at, input int chg_nlog, input int chg_cp);
    int idx = 0, budget = 0, cur_nlog = nlog, cur_cp = cp;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (idx == chg_at) begin cur_nlog = chg_nlog; cur_cp = chg_cp; end
      in_valid  = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_r      = ramp ? DATA_W'(idx) : DATA_W'($urandom);
      in_i      = ramp ? DATA_W'(-idx) : DATA_W'($urandom);
      nfft_log2 = 4'(cur_nlog);
      cp_len    = ADDR_W'(cur_cp);
      #1;
      if (in_valid && !in_ready && !stall_seen) begin stall_seen = 1; stall_acc = total_acc; end
      if (stall_seen && in_ready && ready_back < 0) ready_back = cyc;
      if (in_valid && in_ready) begin
        model_accept(in_r, in_i, cur_nlog, cur_cp);
        last_acc = cyc;
        total_acc++;
        idx++;
        done = (sym_cnt == 0);
      end
      budget++;
      if (budget > 8000) begin
        check("drv_timeout", budget, 0);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int b = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || mid_sym) && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", b >= 5000, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    sym_cnt = 0;
    mid_sym = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int b;
    reset = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; nfft_log2 = 4'd6; cp_len = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_outs", {out_valid, out_sym_start, out_cp_flag, sym_done, cfg_err, out_r, out_i}, '0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1;

    // Single N=64 ramp symbol with a 16-sample prefix.
    clear_stats();
    send_sym(6, 16, 1, 0, -1, 0, 0);
    drain();
    check("t1_count", valid_cnt, 80);
    check("t1_cp_cnt", cp_cnt, 16);
    check("t1_latency", first_valid - last_acc, 2);
    check("t1_cfg_err", err_cnt, exp_err);

    // Two back-to-back symbols must form one unbroken 160-sample run.
    clear_stats();
    send_sym(6, 16, 0, 0, -1, 0, 0);
    send_sym(6, 16, 0, 0, -1, 0, 0);
    drain();
    check("t2_run", max_run, 160);
    check("t2_count", valid_cnt, 160);

    // Three N=128 symbols: input stalls once both banks fill.
    clear_stats();
    repeat (3) send_sym(7, 9, 0, 0, -1, 0, 0);
    drain();
    check("t3_stall_seen", stall_seen, 1'b1);
    check("t3_stall_at", stall_acc, 256);
    check("t3_ready_back", ready_back, first_done);
    check("t3_count", valid_cnt, 3 * 137);

    // cp_len equal to N is clamped to N-1 and flagged once.
    clear_stats();
    send_sym(6, 64, 0, 0, -1, 0, 0);
    drain();
    check("t4_clamp_err", err_cnt, 1);
    check("t4_clamp_count", valid_cnt, 127);

    // Zero-length prefix.
    clear_stats();
    send_sym(6, 0, 0, 0, -1, 0, 0);
    drain();
    check("t4_cp0_flag", cp_cnt, 0);
    check("t4_cp0_count", valid_cnt, 64);
    check("t4_cp0_err", err_cnt, 0);

    // Reset in the middle of the prefix, then a clean symbol.
    clear_stats();
    send_sym(6, 16, 1, 0, -1, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    b = 0;
    while (cp_cnt < 5 && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("t5_reached_cp", cp_cnt >= 5, 1'b1);
    do_reset();
    clear_stats();
    send_sym(6, 16, 0, 0, -1, 0, 0);
    drain();
    check("t5_count", valid_cnt, 80);

    // Config change mid-symbol applies only to the next symbol.
    clear_stats();
    send_sym(6, 16, 0, 0, 10, 7, 20);
    send_sym(7, 16, 0, 0, -1, 0, 0);
    drain();
    check("t6_count", valid_cnt, 80 + 144);

    // Randomised symbols with input gaps, including out-of-range configs.
    clear_stats();
    for (int s = 0; s < 6; s++) begin
      int nl, cp;
      nl = (s == 3) ? 5 : 6 + $urandom_range(2);
      cp = (s == 4) ? 300 : $urandom_range(70);
      send_sym(nl, cp, 0, 1, -1, 0, 0);
    end
    drain();
    check("t7_cfg_err", err_cnt, exp_err);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pusch_cp_inserter.md
Name: pusch_cp_inserter

Overview:
- Cyclic-prefix insertion stage directly downstream of the IFFT in the PUSCH transmit chain.
- Accepts one OFDM symbol of N time-domain complex samples per symbol, serially.
- Emits the last cp_len samples (the cyclic prefix), then all N samples, as one continuous stream to the PUSCH top-level Data_r/Data_i/Data_valid outputs.
- Uses a two-bank ping-pong buffer, so one symbol can be written while the previous one is read out.

Parameters:
- DATA_W, 15, sample width per real/imag component (two's complement).
- ADDR_W, 11, log2 of maximum FFT size; buffer depth per bank is 2^ADDR_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  IFFT sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_r  input  DATA_W  IFFT real sample, signed.
- in_i  input  DATA_W  IFFT imag sample, signed.
- nfft_log2  input  4  log2(N); legal values 6..ADDR_W.
- cp_len  input  ADDR_W  cyclic prefix length in samples.
- out_r  output  DATA_W  output real sample, signed.
- out_i  output  DATA_W  output imag sample, signed.
- out_valid  output  1  output sample valid.
- out_sym_start  output  1  pulse on the first output sample of a symbol.
- out_cp_flag  output  1  high while the current output sample belongs to the CP.
- sym_done  output  1  pulse on the last output sample of a symbol.
- cfg_err  output  1  one-cycle pulse on an illegal config at symbol capture.

Behaviour:
- Reset (synchronous, active-high, clk):
  - Both banks marked empty; write bank = 0, read bank = 0; counters = 0.
  - Reader in IDLE.
  - out_valid, out_sym_start, out_cp_flag, sym_done, cfg_err = 0.
  - out_r = out_i = 0.
  - in_ready = 0 while reset is high.
  - Reset mid-symbol discards all buffered and partially written data; no output follows.
- Writer:
  - in_ready = !reset && !full[wr_bank].
  - A sample is accepted when in_valid && in_ready.
  - On the first accept into a bank, nfft_log2 and cp_len are latched into that bank's config registers.
  - If cp_len >= N, the stored cp_len = N-1 and cfg_err pulses on the following cycle.
  - If nfft_log2 is outside 6..ADDR_W, it is stored as ADDR_W and cfg_err pulses.
  - Samples are written at wr_addr = 0..N-1.
  - On the accept of sample N-1: full[wr_bank] is set (visible next cycle), wr_bank toggles, wr_addr = 0.
  - Config inputs are ignored mid-symbol.
- Reader FSM states: IDLE, CP, BODY.
  - IDLE -> CP when full[rd_bank]. The read address is issued that cycle.
  - CP:
    - Reads addresses N-cp_len .. N-1.
    - If the stored cp_len = 0, the FSM skips directly to BODY.
  - BODY:
    - Reads addresses 0..N-1.
    - On issuing address N-1: full[rd_bank] is cleared, rd_bank toggles.
    - Next state is CP if the other bank is already full (including a full flag set in that same cycle), else IDLE.
- Buffer timing:
  - The buffer has a 1-cycle synchronous read.
  - Output registers (out_*) are valid the cycle after the address is issued.
- Latency:
  - The last input sample is accepted in cycle T with the reader IDLE.
  - The first out_valid occurs at T+2.
- Output stream:
  - Exactly N+cp_len consecutive out_valid cycles per symbol, with no gaps and no backpressure.
  - Back-to-back full banks produce zero idle cycles between symbols.
  - out_sym_start is high on output sample 0.
  - out_cp_flag is high on output samples 0..cp_len-1.
  - sym_done is high on output sample N+cp_len-1.
  - When out_valid = 0, out_r/out_i hold 0.
- Simultaneous events:
  - A write to bank k and a read from bank k-1 in the same cycle is legal.
  - The writer never touches a full bank.
  - The reader never reads an empty bank.
- Throughput: input stalls (in_ready = 0) only when both banks are full.

Test Plan:
- N=64 (nfft_log2=6), cp_len=16, input ramp in_r=0..63, in_i=-in_r:
  - out_r sequence is 48..63 followed by 0..63 (80 valid cycles).
  - out_cp_flag high for the first 16 cycles.
  - out_sym_start on the first sample, sym_done on the 80th.
  - First out_valid 2 cycles after the last input accept.
- Two symbols streamed with continuous in_valid (N=64, cp_len=16):
  - Second symbol output begins the cycle after the first symbol's sym_done.
  - 160 consecutive out_valid cycles in total.
- Three symbols with in_valid held high (N=128, cp_len=9):
  - in_ready falls after 256 accepted samples.
  - in_ready returns high the cycle after the first bank's last read address is issued.
  - No samples are lost or duplicated (checked against a reference model).
- Config edge cases (N=64):
  - cp_len=64: clamped to 63, cfg_err pulses once, 127 output samples.
  - cp_len=0: out_cp_flag never asserts, exactly 64 output samples.
- Reset asserted for 1 cycle midway through the CP output of a symbol:
  - out_valid = 0 the next cycle; in_ready = 1 the cycle after reset deasserts.
  - A new 64-sample symbol then produces a clean 80-sample output.
- Config change mid-symbol (nfft_log2 6->7 after 10 samples):
  - The current symbol still uses N=64.
  - The next symbol uses N=128.
